// File: rtl/fp_round_pack.sv
// ---------------------------------------------------------------------------
// fp_round_pack
//   Final stage of the FP32 add pipeline. Accepts the unpacked sum from the
//   adder/normaliser, rounds it according to the requested rounding mode, and
//   packs an IEEE-754 single-precision result together with exception flags.
//
//   Two register stages with valid/ready backpressure:
//     S1 : rounding (increment decision, carry, adjusted exponent)
//     S2 : classification / packing into the output registers
//   The stage-advance terms are combinational from out_rdy, so a full pipe
//   streams one beat per clock with no bubbles.
//
// Ports
//   clk, rst   clock and synchronous active-high reset
//   in_vld     input beat valid
//   in_rdy     pipe can take a beat this cycle
//   in_class   00 OK, 01 NAN, 10 INF, 11 NUL (zero)
//   in_sign    result sign
//   in_exp     signed biased exponent of in_mant[26]
//   in_mant    [26] hidden one, [25:3] fraction, [2] guard, [1] round, [0] sticky
//   in_rm      00 RNE, 01 RTZ, 10 RUP (+inf), 11 RDN (-inf)
//   out_vld    result valid
//   out_rdy    downstream accepts the result
//   out_data   packed IEEE-754 single
//   out_flags  {invalid, overflow, underflow, inexact}
// ---------------------------------------------------------------------------
module fp_round_pack #(
  parameter int          EXP_W = 10,
  parameter logic [31:0] QNAN  = 32'h7FC0_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_vld,
  output logic                    in_rdy,
  input  logic [1:0]              in_class,
  input  logic                    in_sign,
  input  logic signed [EXP_W-1:0] in_exp,
  input  logic [26:0]             in_mant,
  input  logic [1:0]              in_rm,
  output logic                    out_vld,
  input  logic                    out_rdy,
  output logic [31:0]             out_data,
  output logic [3:0]              out_flags
);

  localparam logic [1:0] CLS_OK  = 2'b00;
  localparam logic [1:0] CLS_NAN = 2'b01;
  localparam logic [1:0] CLS_INF = 2'b10;
  localparam logic [1:0] CLS_NUL = 2'b11;

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_RUP = 2'b10;
  localparam logic [1:0] RM_RDN = 2'b11;

  // One extra bit over the input width so that exp + carry never wraps.
  localparam logic signed [EXP_W:0] EXP_OVF  = (EXP_W+1)'(255);
  localparam logic signed [EXP_W:0] EXP_ZERO = '0;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic s1_vld_q, s1_vld_d;
  logic out_vld_q, out_vld_d;
  logic s2_adv;
  logic s1_adv;

  always_comb begin
    s2_adv = !out_vld_q || out_rdy;
    s1_adv = !s1_vld_q || s2_adv;
    in_rdy = s1_adv;
  end

  // ---------------------------------------------------------------------------
  // S1: rounding
  // ---------------------------------------------------------------------------
  logic                 rnd_lsb;
  logic                 rnd_g;
  logic                 rnd_r;
  logic                 rnd_s;
  logic                 rnd_inexact;
  logic                 rnd_up;
  logic [24:0]          rnd_m25;
  logic                 rnd_carry;
  logic [22:0]          rnd_frac;
  logic signed [EXP_W:0] rnd_exp;
  logic                 rnd_mant_zero;

  always_comb begin
    rnd_lsb     = in_mant[3];
    rnd_g       = in_mant[2];
    rnd_r       = in_mant[1];
    rnd_s       = in_mant[0];
    rnd_inexact = rnd_g | rnd_r | rnd_s;

    rnd_up = 1'b0;
    case (in_rm)
      RM_RNE:  rnd_up = rnd_g & (rnd_r | rnd_s | rnd_lsb);
      RM_RTZ:  rnd_up = 1'b0;
      RM_RUP:  rnd_up = rnd_inexact & !in_sign;
      RM_RDN:  rnd_up = rnd_inexact & in_sign;
      default: rnd_up = 1'b0;
    endcase

    rnd_m25   = {1'b0, in_mant[26:3]} + {24'd0, rnd_up};
    rnd_carry = rnd_m25[24];
    // A carry out of the significand can only come from all-ones + 1, so the
    // shifted fraction is zero and the exponent absorbs the carry.
    rnd_frac  = rnd_carry ? rnd_m25[23:1] : rnd_m25[22:0];

    rnd_exp = {in_exp[EXP_W-1], in_exp} + {{EXP_W{1'b0}}, rnd_carry};

    rnd_mant_zero = (in_mant == 27'd0);
  end

  logic [1:0]            s1_class_q,   s1_class_d;
  logic                  s1_sign_q,    s1_sign_d;
  logic [1:0]            s1_rm_q,      s1_rm_d;
  logic signed [EXP_W:0] s1_exp_q,     s1_exp_d;
  logic [22:0]           s1_frac_q,    s1_frac_d;
  logic                  s1_inexact_q, s1_inexact_d;
  logic                  s1_zero_q,    s1_zero_d;

  always_comb begin
    s1_vld_d     = s1_vld_q;
    s1_class_d   = s1_class_q;
    s1_sign_d    = s1_sign_q;
    s1_rm_d      = s1_rm_q;
    s1_exp_d     = s1_exp_q;
    s1_frac_d    = s1_frac_q;
    s1_inexact_d = s1_inexact_q;
    s1_zero_d    = s1_zero_q;

    if (s1_adv) begin
      s1_vld_d = in_vld;
    end

    // Payload only loads with a real beat, so an idle cycle leaves it intact.
    if (s1_adv && in_vld) begin
      s1_class_d   = in_class;
      s1_sign_d    = in_sign;
      s1_rm_d      = in_rm;
      s1_exp_d     = rnd_exp;
      s1_frac_d    = rnd_frac;
      s1_inexact_d = rnd_inexact;
      s1_zero_d    = rnd_mant_zero;
    end
  end

  // ---------------------------------------------------------------------------
  // S2: pack
  // ---------------------------------------------------------------------------
  logic [31:0] pack_data;
  logic [3:0]  pack_flags;
  logic        ovf_to_inf;

  always_comb begin
    pack_data  = 32'd0;
    pack_flags = 4'd0;

    // Overflow goes to infinity when the rounding direction points away from
    // zero for this sign; otherwise it saturates at the largest finite value.
    ovf_to_inf = 1'b0;
    case (s1_rm_q)
      RM_RNE:  ovf_to_inf = 1'b1;
      RM_RTZ:  ovf_to_inf = 1'b0;
      RM_RUP:  ovf_to_inf = !s1_sign_q;
      RM_RDN:  ovf_to_inf = s1_sign_q;
      default: ovf_to_inf = 1'b1;
    endcase

    if (s1_class_q == CLS_NAN) begin
      pack_data  = QNAN;
      pack_flags = 4'b1000;
    end else if (s1_class_q == CLS_INF) begin
      pack_data  = {s1_sign_q, 8'hFF, 23'd0};
      pack_flags = 4'b0000;
    end else if (s1_class_q == CLS_NUL || s1_zero_q) begin
      pack_data  = {s1_sign_q, 31'd0};
      pack_flags = 4'b0000;
    end else if (s1_exp_q >= EXP_OVF) begin
      pack_data  = ovf_to_inf ? {s1_sign_q, 8'hFF, 23'd0}
                              : {s1_sign_q, 8'hFE, 23'h7F_FFFF};
      pack_flags = 4'b0101;
    end else if (s1_exp_q <= EXP_ZERO) begin
      // No subnormal support: tiny results flush to a signed zero.
      pack_data  = {s1_sign_q, 31'd0};
      pack_flags = 4'b0011;
    end else begin
      pack_data  = {s1_sign_q, s1_exp_q[7:0], s1_frac_q};
      pack_flags = {3'b000, s1_inexact_q};
    end
  end

  logic [31:0] out_data_q,  out_data_d;
  logic [3:0]  out_flags_q, out_flags_d;

  always_comb begin
    out_vld_d   = out_vld_q;
    out_data_d  = out_data_q;
    out_flags_d = out_flags_q;

    if (s2_adv) begin
      out_vld_d = s1_vld_q;
    end

    if (s2_adv && s1_vld_q) begin
      out_data_d  = pack_data;
      out_flags_d = pack_flags;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q     <= 1'b0;
      s1_class_q   <= CLS_OK;
      s1_sign_q    <= 1'b0;
      s1_rm_q      <= RM_RNE;
      s1_exp_q     <= '0;
      s1_frac_q    <= '0;
      s1_inexact_q <= 1'b0;
      s1_zero_q    <= 1'b0;
      out_vld_q    <= 1'b0;
      out_data_q   <= '0;
      out_flags_q  <= '0;
    end else begin
      s1_vld_q     <= s1_vld_d;
      s1_class_q   <= s1_class_d;
      s1_sign_q    <= s1_sign_d;
      s1_rm_q      <= s1_rm_d;
      s1_exp_q     <= s1_exp_d;
      s1_frac_q    <= s1_frac_d;
      s1_inexact_q <= s1_inexact_d;
      s1_zero_q    <= s1_zero_d;
      out_vld_q    <= out_vld_d;
      out_data_q   <= out_data_d;
      out_flags_q  <= out_flags_d;
    end
  end

  assign out_vld   = out_vld_q;
  assign out_data  = out_data_q;
  assign out_flags = out_flags_q;

endmodule

// File: tb/tb_fp_round_pack.sv
module tb_fp_round_pack;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_vld;
  logic              in_rdy;
  logic [1:0]        in_class;
  logic              in_sign;
  logic signed [9:0] in_exp;
  logic [26:0]       in_mant;
  logic [1:0]        in_rm;
  logic              out_vld;
  logic              out_rdy;
  logic [31:0]       out_data;
  logic [3:0]        out_flags;

  fp_round_pack #(.EXP_W(10), .QNAN(32'h7FC0_0000)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .in_class (in_class),
    .in_sign  (in_sign),
    .in_exp   (in_exp),
    .in_mant  (in_mant),
    .in_rm    (in_rm),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_data (out_data),
    .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int xfers = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  // Reference model: value-level IEEE rounding on the integer significand.
  function automatic logic [35:0] model(input logic [1:0] cls, input logic sgn,
                                        input int e_in, input logic [26:0] m,
                                        input logic [1:0] rm);
    int  sig;
    int  rem;
    int  e;
    bit  up;
    bit  inx;
    bit  to_inf;
    e = e_in;
    if (cls == 2'b01) return {32'h7FC0_0000, 4'b1000};
    if (cls == 2'b10) return {sgn, 8'hFF, 23'h0, 4'b0000};
    if (cls == 2'b11 || m == 27'd0) return {sgn, 31'h0, 4'b0000};
    sig = int'(m >> 3);
    rem = int'(m & 27'd7);
    inx = (rem != 0);
    case (rm)
      2'b00:   up = (rem > 4) || (rem == 4 && (sig % 2) == 1);
      2'b01:   up = 1'b0;
      2'b10:   up = inx && !sgn;
      default: up = inx && sgn;
    endcase
    sig = sig + int'(up);
    if (sig == (1 << 24)) begin
      sig = sig / 2;
      e = e + 1;
    end
    if (e >= 255) begin
      to_inf = (rm == 2'b00) || (rm == 2'b10 && !sgn) || (rm == 2'b11 && sgn);
      return to_inf ? {sgn, 8'hFF, 23'h0, 4'b0101} : {sgn, 8'hFE, 23'h7FFFFF, 4'b0101};
    end
    if (e <= 0) return {sgn, 31'h0, 4'b0011};
    return {sgn, 8'(e), 23'(sig), 3'b000, inx};
  endfunction

  // Scoreboard / compare process: sampled on the falling edge.
  logic [35:0] exp_q[$];
  logic        hold_valid = 1'b0;
  logic [35:0] hold_word;
  logic [35:0] w;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      hold_valid = 1'b0;
    end else begin
      check("in_rdy", 64'(in_rdy), 64'(!(exp_q.size() == 2 && !out_rdy)));
      if (hold_valid) begin
        check("hold_vld", 64'(out_vld), 64'd1);
        check("hold_data", 64'({out_data, out_flags}), 64'(hold_word));
      end
      hold_valid = out_vld && !out_rdy;
      hold_word  = {out_data, out_flags};
      if (out_vld && out_rdy) begin
        xfers++;
        if (exp_q.size() == 0) check("spurious_out", 64'(out_vld), 64'd0);
        else begin
          w = exp_q.pop_front();
          check("out_word", 64'({out_data, out_flags}), 64'(w));
        end
      end
      if (in_vld && in_rdy)
        exp_q.push_back(model(in_class, in_sign, int'(in_exp), in_mant, in_rm));
    end
  end

  typedef struct {
    logic [1:0]        cls;
    logic              sgn;
    logic signed [9:0] e;
    logic [26:0]       m;
    logic [1:0]        rm;
  } vec_t;

  vec_t vecs[$];

  task automatic drive(input vec_t v);
    in_class = v.cls;
    in_sign  = v.sgn;
    in_exp   = v.e;
    in_mant  = v.m;
    in_rm    = v.rm;
  endtask

  task automatic add(input logic [1:0] cls, input logic sgn, input int e,
                     input logic [26:0] m, input logic [1:0] rm);
    vec_t v;
    v.cls = cls; v.sgn = sgn; v.e = 10'(e); v.m = m; v.rm = rm;
    vecs.push_back(v);
  endtask

  // Single beat through an empty pipe with out_rdy=1, literal expectation.
  task automatic one_beat(input string name, input logic [1:0] cls, input logic sgn,
                          input int e, input logic [26:0] m, input logic [1:0] rm,
                          input logic [31:0] wd, input logic [3:0] wf);
    vec_t v;
    v.cls = cls; v.sgn = sgn; v.e = 10'(e); v.m = m; v.rm = rm;
    drive(v);
    out_rdy = 1'b1;
    in_vld  = 1'b1;
    @(posedge clk); #1;
    in_vld = 1'b0;
    check({name, "_lat1"}, 64'(out_vld), 64'd0);
    @(posedge clk); #1;
    check({name, "_lat2"}, 64'(out_vld), 64'd1);
    check({name, "_data"}, 64'(out_data), 64'(wd));
    check({name, "_flags"}, 64'(out_flags), 64'(wf));
    @(posedge clk); #1;
  endtask

  // mode 0: out_rdy=1, 1: toggle 1010..., 2: random
  task automatic run_stream(input int mode);
    int idx;
    int cyc;
    int n;
    bit go;
    idx = 0;
    cyc = 0;
    while (idx < vecs.size() && cyc < 200) begin
      out_rdy = (mode == 0) ? 1'b1 : (mode == 1) ? 1'((cyc % 2) == 0) : 1'($urandom_range(0, 1));
      drive(vecs[idx]);
      in_vld = 1'b1;
      @(negedge clk);
      go = in_vld && in_rdy;
      @(posedge clk); #1;
      if (go) idx++;
      cyc++;
    end
    in_vld = 1'b0;
    check("stream_accept_all", 64'(idx), 64'(vecs.size()));
    if (mode == 0) check("no_bubble_cycles", 64'(cyc), 64'(vecs.size()));
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      out_rdy = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    out_rdy = 1'b1;
    vecs.delete();
  endtask

  int x0;

  initial begin
    rst      = 1'b1;
    in_vld   = 1'b0;
    in_class = 2'b00;
    in_sign  = 1'b0;
    in_exp   = '0;
    in_mant  = '0;
    in_rm    = 2'b00;
    out_rdy  = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_out_vld", 64'(out_vld), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_flags", 64'(out_flags), 64'd0);
    check("rst_in_rdy", 64'(in_rdy), 64'd1);

    one_beat("one",      2'b00, 1'b0, 127, 27'h4000000, 2'b00, 32'h3F80_0000, 4'b0000);
    one_beat("tie_odd",  2'b00, 1'b0, 127, 27'h400000C, 2'b00, 32'h3F80_0002, 4'b0001);
    one_beat("tie_even", 2'b00, 1'b0, 127, 27'h4000014, 2'b00, 32'h3F80_0002, 4'b0001);
    one_beat("ovf_rne",  2'b00, 1'b0, 254, 27'h7FFFFFC, 2'b00, 32'h7F80_0000, 4'b0101);
    one_beat("ovf_rtz",  2'b00, 1'b0, 255, 27'h7FFFFF8, 2'b01, 32'h7F7F_FFFF, 4'b0101);
    one_beat("ovf_rdn",  2'b00, 1'b0, 300, 27'h4000000, 2'b11, 32'h7F7F_FFFF, 4'b0101);
    one_beat("ovf_rup_n",2'b00, 1'b1, 256, 27'h4000000, 2'b10, 32'hFF7F_FFFF, 4'b0101);
    one_beat("uflow",    2'b00, 1'b0, 0,   27'h4000000, 2'b00, 32'h0000_0000, 4'b0011);
    one_beat("uflow_neg",2'b00, 1'b1, -5,  27'h4000001, 2'b01, 32'h8000_0000, 4'b0011);
    one_beat("nan",      2'b01, 1'b1, 127, 27'h4000000, 2'b00, 32'h7FC0_0000, 4'b1000);
    one_beat("inf_neg",  2'b10, 1'b1, 127, 27'h4000000, 2'b00, 32'hFF80_0000, 4'b0000);
    one_beat("mant_zero",2'b00, 1'b1, 127, 27'h0,       2'b00, 32'h8000_0000, 4'b0000);
    one_beat("rup_pos",  2'b00, 1'b0, 128, 27'h4000001, 2'b10, 32'h4000_0001, 4'b0001);

    // Full-rate stream, no stalls.
    add(2'b00, 1'b0, 127, 27'h400000C, 2'b00);
    add(2'b00, 1'b1, 130, 27'h5555557, 2'b11);
    add(2'b00, 1'b0, 254, 27'h7FFFFFC, 2'b01);
    add(2'b11, 1'b0, 100, 27'h4000000, 2'b00);
    add(2'b00, 1'b0, 1,   27'h7FFFFFF, 2'b10);
    add(2'b01, 1'b0, 0,   27'h0,       2'b00);
    run_stream(0);

    // Eight beats against a 1010... out_rdy pattern.
    add(2'b00, 1'b0, 127, 27'h4000000, 2'b00);
    add(2'b00, 1'b1, 127, 27'h400000C, 2'b00);
    add(2'b00, 1'b0, 200, 27'h6AAAAAB, 2'b10);
    add(2'b00, 1'b1, 200, 27'h6AAAAAB, 2'b10);
    add(2'b10, 1'b0, 50,  27'h4000000, 2'b00);
    add(2'b00, 1'b1, 254, 27'h7FFFFFF, 2'b11);
    add(2'b00, 1'b0, -3,  27'h4000004, 2'b00);
    add(2'b00, 1'b0, 64,  27'h4123456, 2'b01);
    run_stream(1);

    // Random stalls.
    for (int i = 0; i < 12; i++)
      add(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 260)) - 2,
          27'h4000000 | 27'($urandom_range(0, 32'h3FFFFFF)), 2'($urandom_range(0, 3)));
    run_stream(2);

    // Reset with two beats in flight.
    out_rdy  = 1'b0;
    in_class = 2'b00; in_sign = 1'b0; in_exp = 10'sd127; in_mant = 27'h4000000; in_rm = 2'b00;
    in_vld   = 1'b1;
    @(posedge clk); #1;
    in_mant  = 27'h4000008;
    @(posedge clk); #1;
    in_vld = 1'b0;
    rst    = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_out_vld", 64'(out_vld), 64'd0);
    check("mid_rst_out_data", 64'(out_data), 64'd0);
    check("mid_rst_flags", 64'(out_flags), 64'd0);
    x0 = xfers;
    one_beat("post_rst", 2'b00, 1'b1, 128, 27'h4000000, 2'b00, 32'hC000_0000, 4'b0000);
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_alone", 64'(xfers), 64'(x0 + 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
